regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Write-back scheduler for the 32x32 register file write port.
- Arbitrates between two write-back sources: req0 = ALU result, req1 = memory load data.
- Sources are arbitrated round-robin; the winner is registered into the file's single write port.
- Keeps a pending-write scoreboard, one bit per register, and raises a hazard to the issue stage on RAW/WAW conflicts against writes still in flight.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width (2**ADDR_W registers).
- NREG, 32, number of registers tracked by the scoreboard (must equal 2**ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- alloc_en  input  1  issue stage reserves a destination register this cycle.
- alloc_dst  input  ADDR_W  register being reserved.
- rs_addr  input  ADDR_W  first source register of the instruction at issue.
- rt_addr  input  ADDR_W  second source register of the instruction at issue.
- hazard  output  1  issue must stall (combinational).
- req0_valid  input  1  ALU write-back request.
- req0_addr  input  ADDR_W  ALU destination register.
- req0_data  input  DATA_W  ALU result.
- req0_ready  output  1  req0 accepted this cycle (combinational).
- req1_valid  input  1  load write-back request.
- req1_addr  input  ADDR_W  load destination register.
- req1_data  input  DATA_W  load data.
- req1_ready  output  1  req1 accepted this cycle (combinational).
- rf_we  output  1  register file write strobe (registered).
- rf_waddr  output  ADDR_W  register file write address (registered).
- rf_wdata  output  DATA_W  register file write data (registered).
- pending  output  NREG  scoreboard bitmap (registered).

Behaviour:
- **Reset** (async, immediate):
  - rf_we=0, rf_waddr=0, rf_wdata=0, pending=0.
  - Round-robin pointer set to favour req0.
  - Reset mid-transfer discards any registered write: rf_we drops to 0 without waiting for the clock.
- **Handshake:** a transfer occurs when reqN_valid && reqN_ready. At most one ready per cycle. A source holds valid/addr/data stable until accepted.
- **Arbitration** (combinational grant, one accept per cycle, no back-pressure from the file):
  - Only one source valid → it is granted.
  - Both valid → the source not served by the previous grant wins.
  - The pointer updates only on an actual grant; idle cycles leave it unchanged.
- **Write stage latency:** data accepted in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1. With no accept in cycle N, rf_we=0 in cycle N+1; addr/data hold their previous values.
- **Register 0:** a request with addr 0 is accepted normally (ready asserted, pointer advances), but rf_we stays 0 for it.
- **Scoreboard:**
  - alloc_en with alloc_dst≠0 sets pending[alloc_dst] at the clock edge.
  - A cycle with rf_we=1 clears pending[rf_waddr] at the clock edge.
  - Alloc and commit to the same register in the same cycle: set wins, bit stays 1.
  - alloc_dst=0 is ignored.
  - pending[0] is always 0.
- **Hazard** (combinational):
  - hazard = pending[rs_addr] | pending[rt_addr] | (alloc_en & pending[alloc_dst]).
  - Address 0 never contributes.
  - Issue must not assert alloc_en while hazard=1. If it does anyway, the bit remains set (no counting, no error flag).
- A commit clears the bit only after the file has been written, so a dependent read issued the cycle after the clear sees the new value.

Test Plan:
- **Reset during traffic:** assert reset while rf_we=1 → rf_we=0 immediately; pending=0; next both-valid cycle grants req0.
- **Single write:** alloc_en, alloc_dst=8 → pending[8]=1. Then req0 addr=8, data=0xDEADBEEF → req0_ready=1; next cycle rf_we=1, rf_waddr=8, rf_wdata=0xDEADBEEF; following cycle pending[8]=0.
- **Round-robin:** req0 and req1 both valid for 4 cycles (addrs 9/10) → grants alternate 0,1,0,1; exactly one ready per cycle; four consecutive rf_we pulses in that order.
- **Hazard:** pending[16]=1, rs_addr=16 → hazard=1. rs_addr=17, rt_addr=16 → hazard=1. rs=rt=0 with all other bits set → hazard=0. alloc_en with alloc_dst=16 → hazard=1.
- **Register 0:** req1 addr=0, data=0x12345678 → req1_ready=1, no rf_we pulse, pending unchanged; alloc_dst=0 leaves pending[0]=0.
- **Same-cycle alloc and commit:** rf_we=1, rf_waddr=12 in the same cycle as alloc_en, alloc_dst=12 → pending[12] stays 1 afterwards.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler for the register file write port: round-robin between ALU and load
// results, one registered write per cycle, plus a pending-write scoreboard driving the issue hazard.
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_dst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              hazard,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NREG-1:0]   pending
);

    logic              r_prio1;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [NREG-1:0]   r_pending;

    logic              w_acc0;
    logic              w_acc1;
    logic              w_accept;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_data;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;
    logic [NREG-1:0]   w_pending_nxt;

    // r_prio1 = 1 means req1 wins a tie; it flips to the loser after every real grant.
    always_comb begin
        w_acc0     = req0_valid & (~req1_valid | ~r_prio1);
        w_acc1     = req1_valid & (~req0_valid |  r_prio1);
        w_accept   = w_acc0 | w_acc1;
        w_acc_addr = w_acc1 ? req1_addr : req0_addr;
        w_acc_data = w_acc1 ? req1_data : req0_data;
    end

    assign req0_ready = w_acc0;
    assign req1_ready = w_acc1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio1 <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            // Register-0 writes are consumed but never strobed into the file.
            r_we <= w_accept & (w_acc_addr != '0);
            if (w_accept) begin
                r_prio1 <= w_acc0;
                r_waddr <= w_acc_addr;
                r_wdata <= w_acc_data;
            end
        end
    end

    // Set is applied after clear so a same-cycle re-allocation keeps the bit.
    always_comb begin
        w_set         = alloc_en ? (NREG'(1) << alloc_dst) : '0;
        w_clr         = r_we     ? (NREG'(1) << r_waddr)   : '0;
        w_pending_nxt = ((r_pending & ~w_clr) | w_set) & ~NREG'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign hazard   = r_pending[rs_addr] | r_pending[rt_addr] | (alloc_en & r_pending[alloc_dst]);
    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign pending  = r_pending;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: a bench-side round-robin model pushes expected
// file writes into a queue and a negedge monitor pops them against rf_we/rf_waddr/rf_wdata.
module tb_regfile_wb_scheduler;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_en;
    logic [AW-1:0] alloc_dst;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          hazard;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [NR-1:0] pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t exp_q[$];
    bit  m_prio1;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
        .clk(clk), .reset(reset),
        .alloc_en(alloc_en), .alloc_dst(alloc_dst),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .hazard(hazard),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
    );

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got write addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if (rf_waddr !== e.a || rf_wdata !== e.d) begin
                    errors++;
                    $display("FAIL wb_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             rf_waddr, rf_wdata, e.a, e.d);
                end
            end
        end
    end

    function automatic int exp_grant(input bit v0, input bit v1);
        if (v0 && v1) return m_prio1 ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Model bookkeeping for one accepted request (not a comparison).
    task automatic model_accept(input int g, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        m_prio1 = (g == 0);
        if (a != '0) begin
            e.a = a;
            e.d = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        alloc_en   = 1'b0; alloc_dst = '0; rs_addr = '0; rt_addr = '0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        exp_q.delete();
        m_prio1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        int g;
        do_reset();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || pending !== '0) begin
            errors++;
            $display("FAIL reset_state: got we=%b waddr=%0d wdata=%h pending=%h, required all zero",
                     rf_we, rf_waddr, rf_wdata, pending);
        end
        tick();
        alloc_en = 1'b1; alloc_dst = 5'd7;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hAAAA_5555;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_accept: got req0_ready=%b, required 1", req0_ready);
        end
        model_accept(0, req0_addr, req0_data);
        tick();
        drive_idle();
        checks++;
        if (rf_we !== 1'b1 || pending[7] !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_write: got rf_we=%b pending7=%b, required 1 1", rf_we, pending[7]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rf_we !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL reset_async: got rf_we=%b pending=%h, required 0 0", rf_we, pending);
        end
        exp_q.delete();
        m_prio1 = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0003;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000_0004;
        @(negedge clk);
        g = exp_grant(1'b1, 1'b1);
        checks++;
        if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
            errors++;
            $display("FAIL reset_grant: got ready0=%b ready1=%b, required grant to req%0d", req0_ready, req1_ready, g);
        end
        model_accept(g, g == 0 ? req0_addr : req1_addr, g == 0 ? req0_data : req1_data);
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_single_write();
        do_reset();
        tick();
        alloc_en = 1'b1; alloc_dst = 5'd8;
        tick();
        alloc_en = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (pending[8] !== 1'b1 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: got pending8=%b ready0=%b ready1=%b, required 1 1 0",
                     pending[8], req0_ready, req1_ready);
        end
        model_accept(0, req0_addr, req0_data);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || pending[8] !== 1'b1) begin
            errors++;
            $display("FAIL single_wb: got rf_we=%b pending8=%b, required 1 1", rf_we, pending[8]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (pending[8] !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL single_clear: got pending8=%b rf_we=%b, required 0 0", pending[8], rf_we);
        end
    endtask

    task automatic test_round_robin();
        int g;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        do_reset();
        d0 = 32'h0A00_0000;
        d1 = 32'h0B00_0000;
        tick();
        req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = d0;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = d1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g = exp_grant(1'b1, 1'b1);
            checks++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1) || g != (i % 2)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got ready0=%b ready1=%b model=%0d, required grant to req%0d",
                         i, req0_ready, req1_ready, g, i % 2);
            end
            if (i > 0) begin
                checks++;
                if (rf_we !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_pulse[%0d]: got rf_we=%b, required 1", i, rf_we);
                end
            end
            if (g == 0) begin
                model_accept(g, req0_addr, d0);
                d0 = d0 + 1;
            end else begin
                model_accept(g, req1_addr, d1);
                d1 = d1 + 1;
            end
            tick();
            req0_data = d0;
            req1_data = d1;
        end
        drive_idle();
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1) begin
            errors++;
            $display("FAIL rr_last_pulse: got rf_we=%b, required 1", rf_we);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: got rf_we=%b, required 0", rf_we);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        tick();
        alloc_en = 1'b1; alloc_dst = 5'd16;
        tick();
        alloc_en = 1'b0;
        rs_addr = 5'd16; rt_addr = 5'd0;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL haz_rs: got hazard=%b, required 1", hazard);
        end
        rs_addr = 5'd17; rt_addr = 5'd16;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL haz_rt: got hazard=%b, required 1", hazard);
        end
        rs_addr = 5'd17; rt_addr = 5'd18;
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL haz_clean: got hazard=%b, required 0", hazard);
        end
        rs_addr = '0; rt_addr = '0;
        for (int r = 1; r < NR; r++) begin
            alloc_en = 1'b1; alloc_dst = AW'(r);
            tick();
        end
        alloc_en = 1'b0; alloc_dst = '0;
        #1;
        checks++;
        if (pending !== 32'hFFFF_FFFE || hazard !== 1'b0) begin
            errors++;
            $display("FAIL haz_zero_src: got pending=%h hazard=%b, required fffffffe 0", pending, hazard);
        end
        alloc_en = 1'b1; alloc_dst = 5'd16;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL haz_alloc: got hazard=%b, required 1", hazard);
        end
        alloc_dst = 5'd0;
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL haz_alloc0: got hazard=%b, required 0", hazard);
        end
        tick();
        alloc_en = 1'b0;
        @(negedge clk);
        checks++;
        if (pending !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL haz_keep: got pending=%h, required fffffffe", pending);
        end
    endtask

    task automatic test_reg0();
        int g;
        do_reset();
        tick();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL reg0_ready1: got ready0=%b ready1=%b, required 0 1", req0_ready, req1_ready);
        end
        model_accept(1, req1_addr, req1_data);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h0BAD_0000;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || pending !== '0 || req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL reg0_nowrite: got rf_we=%b pending=%h ready0=%b, required 0 0 1", rf_we, pending, req0_ready);
        end
        model_accept(0, req0_addr, req0_data);
        tick();
        req0_valid = 1'b0;
        alloc_en = 1'b1; alloc_dst = 5'd0;
        tick();
        alloc_en = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_0011;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_0022;
        @(negedge clk);
        checks++;
        if (pending !== '0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reg0_alloc: got pending=%h rf_we=%b, required 0 0", pending, rf_we);
        end
        g = exp_grant(1'b1, 1'b1);
        checks++;
        if (req0_ready !== (g == 0) || req1_ready !== (g == 1) || g != 1) begin
            errors++;
            $display("FAIL reg0_ptr: got ready0=%b ready1=%b, required grant to req1", req0_ready, req1_ready);
        end
        model_accept(g, g == 0 ? req0_addr : req1_addr, g == 0 ? req0_data : req1_data);
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_same_cycle();
        do_reset();
        tick();
        alloc_en = 1'b1; alloc_dst = 5'd12;
        tick();
        alloc_en = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_accept: got ready0=%b, required 1", req0_ready);
        end
        model_accept(0, req0_addr, req0_data);
        tick();
        req0_valid = 1'b0;
        alloc_en = 1'b1; alloc_dst = 5'd12;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd12) begin
            errors++;
            $display("FAIL same_commit: got rf_we=%b waddr=%0d, required 1 12", rf_we, rf_waddr);
        end
        tick();
        alloc_en = 1'b0;
        @(negedge clk);
        checks++;
        if (pending[12] !== 1'b1) begin
            errors++;
            $display("FAIL same_set_wins: got pending12=%b, required 1", pending[12]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (pending[12] !== 1'b1) begin
            errors++;
            $display("FAIL same_hold: got pending12=%b, required 1", pending[12]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_single_write();
        test_round_robin();
        test_hazard();
        test_reg0();
        test_same_cycle();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wb_missing: got %0d outstanding expected writes, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
